// File: rtl/shifter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shifter_rr_arbiter
// Description : Two-requester round-robin arbiter in front of one shared
//               rotate-left/right barrel shifter. The winning op is rotated
//               and captured in a one-deep output register with its own
//               valid/ready handshake. Full throughput of one op per cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous active-high reset
//   req0_valid   in   1      requester 0 has an op
//   req0_data    in   2**N   requester 0 operand
//   req0_amt     in   N      requester 0 rotate amount
//   req0_lr      in   1      requester 0 direction (1 = right, 0 = left)
//   req0_ready   out  1      requester 0 op accepted this cycle
//   req1_*                   same as req0_* for requester 1
//   out_valid    out  1      result register holds a valid result
//   out_data     out  2**N   rotated result
//   out_id       out  1      requester index that produced out_data
//   out_ready    in   1      downstream consumes when out_valid & out_ready
// ============================================================================
module shifter_rr_arbiter #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req0_valid,
    input  logic [(2**N)-1:0]   req0_data,
    input  logic [N-1:0]        req0_amt,
    input  logic                req0_lr,
    output logic                req0_ready,

    input  logic                req1_valid,
    input  logic [(2**N)-1:0]   req1_data,
    input  logic [N-1:0]        req1_amt,
    input  logic                req1_lr,
    output logic                req1_ready,

    output logic                out_valid,
    output logic [(2**N)-1:0]   out_data,
    output logic                out_id,
    input  logic                out_ready
);

    localparam int c_width = 2**N;

    // Output register occupancy
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q,      state_d;
    logic [c_width-1:0]   data_q,       data_d;
    logic                 id_q,         id_d;
    logic                 last_grant_q, last_grant_d;

    logic                 w_can_accept;
    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_accept;
    logic [c_width-1:0]   w_sel_data;
    logic [N-1:0]         w_sel_amt;
    logic                 w_sel_lr;
    logic [c_width-1:0]   w_rot;

    // ------------------------------------------------------------------------
    // Rotate via a doubled operand: the wrapped-around bits are already
    // present in the second copy, so a plain shift and a slice give the
    // rotation without any modulo arithmetic.
    // ------------------------------------------------------------------------
    function automatic logic [c_width-1:0] rotate(
        input logic [c_width-1:0] d,
        input logic [N-1:0]       amt,
        input logic               right
    );
        logic [2*c_width-1:0] dd;
        logic [2*c_width-1:0] sh;
        dd = {d, d};
        if (right) begin
            sh     = dd >> amt;
            rotate = sh[c_width-1:0];
        end else begin
            sh     = dd << amt;
            rotate = sh[2*c_width-1:c_width];
        end
    endfunction

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    assign w_can_accept = (state_q == EMPTY) | out_ready;

    // On a tie the requester that did not win last time takes the grant.
    assign w_grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign w_grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    // Readies are forced low while reset is held so no requester believes
    // an op was taken while the state is being cleared.
    assign req0_ready = w_can_accept & w_grant0 & ~reset;
    assign req1_ready = w_can_accept & w_grant1 & ~reset;
    assign w_accept   = req0_ready | req1_ready;

    // Only the granted requester's payload reaches the shifter, so undefined
    // payload on an idle requester never leaks into the result.
    always_comb begin
        w_sel_data = '0;
        w_sel_amt  = '0;
        w_sel_lr   = 1'b0;
        if (w_grant0) begin
            w_sel_data = req0_data;
            w_sel_amt  = req0_amt;
            w_sel_lr   = req0_lr;
        end else if (w_grant1) begin
            w_sel_data = req1_data;
            w_sel_amt  = req1_amt;
            w_sel_lr   = req1_lr;
        end
    end

    assign w_rot = rotate(w_sel_data, w_sel_amt, w_sel_lr);

    // ------------------------------------------------------------------------
    // Output register next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            EMPTY: begin
                if (w_accept) begin
                    state_d      = FULL;
                    data_d       = w_rot;
                    id_d         = w_grant1;
                    last_grant_d = w_grant1;
                end
            end
            FULL: begin
                if (w_accept) begin
                    // Drain and refill in the same cycle: no bubble.
                    state_d      = FULL;
                    data_d       = w_rot;
                    id_d         = w_grant1;
                    last_grant_d = w_grant1;
                end else if (out_ready) begin
                    // Consumed with nothing to replace it; data is kept.
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            data_q       <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_shifter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_rr_arbiter
// Description : Directed self-checking bench for shifter_rr_arbiter (N=3),
//               followed by a constrained-random phase against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_rr_arbiter;

    localparam int N = 3;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data,  req1_data;
    logic [N-1:0] req0_amt,   req1_amt;
    logic         req0_lr,    req1_lr;
    logic         req0_ready, req1_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_id;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;

    shifter_rr_arbiter #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_lr    (req0_lr),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_lr    (req1_lr),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit reference rotate straight from the index definition.
    function automatic logic [W-1:0] ref_rot(input logic [W-1:0] d, input int amt, input logic right);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (right) r[i] = d[(i + amt) % W];
            else       r[i] = d[(i - amt + W) % W];
        end
        return r;
    endfunction

    // Scoreboard: {id, data} of accepted-but-not-consumed ops
    logic [W:0] sb_q[$];
    logic [W:0] exp_item;

    initial begin
        logic acc0, acc1, cons;
        reset      = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_amt = '0; req0_lr = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_lr = 1'b0;
        out_ready  = 1'b1;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_out_id",    {31'd0, out_id},    32'd0);
        chk("rst_readies",   {30'd0, req1_ready, req0_ready}, 32'd0);
        reset = 1'b0;

        // ---------------- req0 only, rotate left by 1 ----------------
        req0_valid = 1'b1; req0_data = 8'b1000_0001; req0_amt = 3'd1; req0_lr = 1'b0;
        #1;
        chk("t2_readies", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0; req0_data = 'x; req0_amt = 'x; req0_lr = 1'bx;
        chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_out_data",  {24'd0, out_data},  32'h03);
        chk("t2_out_id",    {31'd0, out_id},    32'd0);

        // ---------------- req1 only, rotate right by 4, then pass-through ----
        req1_valid = 1'b1; req1_data = 8'hA5; req1_amt = 3'd4; req1_lr = 1'b1;
        #1;
        chk("t3_readies", {30'd0, req1_ready, req0_ready}, 32'd2);
        @(negedge clk);
        chk("t3_rot_data", {24'd0, out_data}, 32'h5A);
        chk("t3_rot_id",   {31'd0, out_id},   32'd1);
        req1_amt = 3'd0;
        @(negedge clk);
        chk("t3_pass_data", {24'd0, out_data}, 32'hA5);
        chk("t3_pass_id",   {31'd0, out_id},   32'd1);
        req1_valid = 1'b0; req1_data = 'x;
        @(negedge clk);
        chk("t3_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_drain_hold",  {24'd0, out_data},  32'hA5);

        // ---------------- both valid, 6 ops, alternating ----------------
        // last grant was req1, so req0 wins the first tie.
        req0_valid = 1'b1; req0_data = 8'h01; req0_amt = 3'd1; req0_lr = 1'b0; // -> 02
        req1_valid = 1'b1; req1_data = 8'h80; req1_amt = 3'd1; req1_lr = 1'b1; // -> 40
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t4_ready0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t4_ready1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
            chk("t4_out_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_out_id",    {31'd0, out_id},    (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("t4_out_data",  {24'd0, out_data},  (k % 2 == 1) ? 32'h40 : 32'h02);
        end

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_bp_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
            chk("t5_bp_valid", {31'd0, out_valid}, 32'd1);
            chk("t5_bp_id",    {31'd0, out_id},    32'd1);
            chk("t5_bp_data",  {24'd0, out_data},  32'h40);
        end
        out_ready = 1'b1;
        #1;
        chk("t5_rel_readies", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(negedge clk);
        chk("t5_rel_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_rel_id",    {31'd0, out_id},    32'd0);
        chk("t5_rel_data",  {24'd0, out_data},  32'h02);

        // ---------------- async reset mid-stream ----------------
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t1_rst_valid",   {31'd0, out_valid}, 32'd0);
        chk("t1_rst_data",    {24'd0, out_data},  32'd0);
        chk("t1_rst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t1_tie_readies", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(negedge clk);
        chk("t1_tie_id",   {31'd0, out_id},   32'd0);
        chk("t1_tie_data", {24'd0, out_data}, 32'h02);

        // ---------------- drain before random phase ----------------
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 'x; req1_data = 'x;
        out_ready = 1'b1;
        @(negedge clk);
        chk("pre_rand_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- random phase vs queue model ----------------
        acc0 = 1'b1; acc1 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            // A requester may only change its op once it has been taken.
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_data  = req0_valid ? W'($urandom) : 'x;
                req0_amt   = N'($urandom);
                req0_lr    = 1'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_data  = req1_valid ? W'($urandom) : 'x;
                req1_amt   = N'($urandom);
                req1_lr    = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            cons = out_valid & out_ready;
            chk("rand_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            chk("rand_out_valid", {31'd0, out_valid}, (sb_q.size() == 1) ? 32'd1 : 32'd0);
            if (cons) begin
                if (sb_q.size() == 0) begin
                    chk("rand_sb_underflow", 32'd0, 32'd1);
                end else begin
                    exp_item = sb_q.pop_front();
                    chk("rand_out_id",   {31'd0, out_id},   {31'd0, exp_item[W]});
                    chk("rand_out_data", {24'd0, out_data}, {24'd0, exp_item[W-1:0]});
                end
            end
            if (acc0) sb_q.push_back({1'b0, ref_rot(req0_data, int'(req0_amt), req0_lr)});
            if (acc1) sb_q.push_back({1'b1, ref_rot(req1_data, int'(req1_amt), req1_lr)});
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
